mips_multicycle_ctrl: RTL and testbench

Multi-cycle MIPS control FSM that sequences the shared datapath: register enables, memory strobes and all 2:1 / 3:1 operand-mux selects. Decodes opcode and zero flag each instruction, and waits on a memory ready handshake.

3-input select encoding throughout:
- 00 = input0
- 01 = input1
- 10 = input2
- 11 is never driven.

---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/mips_multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory state; expired flags the last allowed stall cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + TMR_W'(1);
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            assign o_expired = (r_count == TMR_W'(MEM_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences datapath enables, memory strobes and mux selects.
//   state      | meaning
//   FETCH      | read instr at PC, PC <- PC+4 on mem_ready
//   DECODE     | ALUOut <- branch target, dispatch on opcode
//   MEMADR     | ALUOut <- A + imm
//   MEMRD/WR   | data memory access, waits on mem_ready
//   MEMWB      | rt <- MDR
//   RTYPE_EX/WB| funct ALU op, rd <- ALUOut
//   BEQ_EX     | compare A,B; PC <- ALUOut if zero
//   ADDI_EX/WB | A + imm, rt <- ALUOut
//   JUMP       | PC <- jump target
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_shift,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next;
    logic   w_stall;
    logic   w_timeout;
    logic   w_hold;
    logic   w_clr;
    logic   w_expired;

    assign w_stall   = is_mem_state(r_state) && !mem_ready;
    assign w_timeout = w_stall && w_expired;
    assign w_hold    = w_stall && !w_timeout;
    // any state change, or a timeout back into FETCH, restarts the count
    assign w_clr     = !w_hold;
    assign state_o   = r_state;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMR_W      (TMR_W)
    ) u_timer (
        .i_clk    (clk),
        .i_rst_n  (reset_n),
        .i_clr    (w_clr),
        .i_en     (w_hold),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        imm_shift  = 1'b0;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        retire     = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        // outputs stay at zero while reset_n is low so strobes drop asynchronously
        if (reset_n) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_4;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                    if (mem_ready) w_next = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM;
                    imm_shift = 1'b1;
                    unique case (opcode)
                        OP_R:          w_next = S_RTYPE_EX;
                        OP_LW, OP_SW:  w_next = S_MEMADR;
                        OP_BEQ:        w_next = S_BEQ_EX;
                        OP_ADDI:       w_next = S_ADDI_EX;
                        OP_J:          w_next = S_JUMP;
                        default: begin
                            illegal_op = 1'b1;
                            w_next     = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if (opcode == OP_LW)      w_next = S_MEMRD;
                    else if (opcode == OP_SW) w_next = S_MEMWR;
                    else                      w_next = S_FETCH;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) w_next = S_MEMWB;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    w_next     = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retire    = mem_ready;
                    if (mem_ready) w_next = S_FETCH;
                end
                S_RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                    w_next    = S_RTYPE_WB;
                end
                S_RTYPE_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_BEQ_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_en     = zero;
                    retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    w_next    = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_JUMP: begin
                    pc_src = PCSRC_JUMP;
                    pc_en  = 1'b1;
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
            if (w_timeout) begin
                pc_en     = 1'b0;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                ir_write  = 1'b0;
                reg_write = 1'b0;
                retire    = 1'b0;
                mem_err   = 1'b1;
                w_next    = S_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: instruction-level model expands each instruction into expected per-cycle outputs.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, imm_shift, retire, illegal_op, mem_err;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_o;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_shift;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       retire, illegal_op, mem_err;
    } outs_t;

    typedef struct {
        logic       rdy;
        logic       z;
        logic [5:0] op;
        outs_t      e;
    } step_t;

    step_t prog[$];
    outs_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    outs_t got;

    assign got = {state_o, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, imm_shift, alu_op, pc_src, retire,
                  illegal_op, mem_err};

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .TMR_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_shift(imm_shift), .alu_op(alu_op),
        .pc_src(pc_src), .retire(retire), .illegal_op(illegal_op), .mem_err(mem_err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, outs_t g, outs_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, g, e);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            outs_t e;
            e = sb.pop_front();
            chk("ctrl_out", got, e);
            cyc++;
        end
    end

    function automatic outs_t blank(state_t s);
        outs_t o;
        o = '0;
        o.st = s;
        return o;
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic push(outs_t e, logic rdy, logic [5:0] op, logic z);
        step_t s;
        s.rdy = rdy; s.z = z; s.op = op; s.e = e;
        prog.push_back(s);
    endtask

    // memory wait: stall cycle k (1-based) aborts when k reaches TO
    task automatic mem_phase(outs_t base, outs_t done, int stalls, output bit aborted);
        outs_t t;
        aborted = 1'b0;
        if (stalls >= TO) begin
            for (int i = 0; i < TO - 1; i++) push(base, 1'b0, rop(), rbit());
            t = base;
            t.pc_en = 0; t.mem_read = 0; t.mem_write = 0; t.ir_write = 0; t.reg_write = 0;
            t.mem_err = 1;
            push(t, 1'b0, rop(), rbit());
            aborted = 1'b1;
        end else begin
            for (int i = 0; i < stalls; i++) push(base, 1'b0, rop(), rbit());
            push(done, 1'b1, rop(), rbit());
        end
    endtask

    task automatic add_instr(logic [5:0] op, int fs, int ms, logic z);
        outs_t f, fd, o, d;
        bit    ab;
        f = blank(S_FETCH); f.mem_read = 1; f.alu_src_b = 2'b01;
        fd = f; fd.ir_write = 1; fd.pc_en = 1;
        mem_phase(f, fd, fs, ab);
        if (ab) return;
        o = blank(S_DECODE); o.alu_src_b = 2'b10; o.imm_shift = 1;
        if (!(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})) begin
            o.illegal_op = 1;
            push(o, rbit(), op, rbit());
            return;
        end
        push(o, rbit(), op, rbit());
        case (op)
            6'b000000: begin
                o = blank(S_RTYPE_EX); o.alu_src_a = 1; o.alu_op = 2'b10;
                push(o, rbit(), rop(), rbit());
                o = blank(S_RTYPE_WB); o.reg_dst = 1; o.reg_write = 1; o.retire = 1;
                push(o, rbit(), rop(), rbit());
            end
            6'b100011, 6'b101011: begin
                o = blank(S_MEMADR); o.alu_src_a = 1; o.alu_src_b = 2'b10;
                push(o, rbit(), op, rbit());
                if (op == 6'b100011) begin
                    o = blank(S_MEMRD); o.mem_read = 1; o.iord = 1;
                    mem_phase(o, o, ms, ab);
                    if (!ab) begin
                        o = blank(S_MEMWB); o.mem_to_reg = 1; o.reg_write = 1; o.retire = 1;
                        push(o, rbit(), rop(), rbit());
                    end
                end else begin
                    o = blank(S_MEMWR); o.mem_write = 1; o.iord = 1;
                    d = o; d.retire = 1;
                    mem_phase(o, d, ms, ab);
                end
            end
            6'b000100: begin
                o = blank(S_BEQ_EX); o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01;
                o.pc_en = z; o.retire = 1;
                push(o, rbit(), rop(), z);
            end
            6'b001000: begin
                o = blank(S_ADDI_EX); o.alu_src_a = 1; o.alu_src_b = 2'b10;
                push(o, rbit(), rop(), rbit());
                o = blank(S_ADDI_WB); o.reg_write = 1; o.retire = 1;
                push(o, rbit(), rop(), rbit());
            end
            default: begin
                o = blank(S_JUMP); o.pc_src = 2'b10; o.pc_en = 1; o.retire = 1;
                push(o, rbit(), rop(), rbit());
            end
        endcase
    endtask

    function automatic int rstall();
        int r;
        r = int'($urandom_range(0, 11));
        if (r < 7)  return int'($urandom_range(0, 3));
        if (r == 7) return TO - 2;
        if (r == 8) return TO - 1;
        if (r == 9) return TO;
        return TO + int'($urandom_range(1, 5));
    endfunction

    // first step is driven immediately; caller sits just after a rising edge with the DUT in FETCH
    task automatic run_prog();
        for (int i = 0; i < prog.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            mem_ready = prog[i].rdy;
            zero      = prog[i].z;
            opcode    = prog[i].op;
            sb.push_back(prog[i].e);
        end
        prog.delete();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [7];
        outs_t      f;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};

        #2;
        chk("reset_idle", got, blank(S_FETCH));
        @(posedge clk);
        #1;
        chk("reset_after_edge", got, blank(S_FETCH));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        add_instr(6'b000000, 0, 0, 1'b0);
        add_instr(6'b100011, 0, 3, 1'b0);
        add_instr(6'b000100, 0, 0, 1'b1);
        add_instr(6'b000100, 0, 0, 1'b0);
        add_instr(6'b000010, 0, 0, 1'b0);
        add_instr(6'b111111, 0, 0, 1'b0);
        add_instr(6'b101011, 0, TO + 4, 1'b0);
        add_instr(6'b101011, 0, TO - 1, 1'b0);
        add_instr(6'b001000, TO, 0, 1'b0);
        add_instr(6'b100011, TO - 1, TO, 1'b0);
        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 7));
            add_instr(k == 7 ? rop() : ops[k], rstall(), rstall(), rbit());
        end
        run_prog();

        // asynchronous reset during the second MEMWR cycle of a store
        @(posedge clk); #1; opcode = 6'b101011; mem_ready = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        f = blank(S_MEMWR); f.mem_write = 1; f.iord = 1;
        chk("memwr_before_reset", got, f);
        reset_n = 1'b0;
        #1;
        chk("async_reset_drop", got, blank(S_FETCH));
        @(posedge clk);
        #1;
        chk("reset_hold", got, blank(S_FETCH));
        reset_n = 1'b1;
        add_instr(6'b000010, 2, 0, 1'b0);
        add_instr(6'b101011, 0, 1, 1'b0);
        run_prog();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
